// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, control-flow opcodes and fetch FSM states.
package cpu_pkg;

  localparam int unsigned CpuAddrW = 8;
  localparam int unsigned CpuDataW = 8;

  localparam logic [7:0] CpuJmpOp = 8'hC0;
  localparam logic [7:0] CpuBrzOp = 8'hC1;

  typedef enum logic [2:0] {
    StIdle,
    StFetchOp,
    StFetchArg,
    StIssue,
    StJump
  } fetch_state_e;

  // Opcodes with both top bits set carry an argument byte.
  function automatic logic is_two_byte(input logic [7:0] op);
    return op[7:6] == 2'b11;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer driving an external program counter and memory handshake.
// Define FETCH_BRANCH_EN to enable the branch-if-zero opcode; otherwise it is a plain two-byte op.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CpuAddrW,
  parameter int unsigned DATA_W = CpuDataW,
  parameter logic [7:0]  JMP_OP = CpuJmpOp,
  parameter logic [7:0]  BRZ_OP = CpuBrzOp
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_value,
  output logic [ADDR_W-1:0] pc_in,
  output logic              pc_inc_en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_op,
  output logic [DATA_W-1:0] instr_arg,
  input  logic              zero_flag
);

  fetch_state_e      state_q, state_d;
  logic [DATA_W-1:0] instr_op_q, instr_op_d;
  logic [DATA_W-1:0] instr_arg_q, instr_arg_d;
  logic [7:0]        op_byte;
  logic              taken;

  assign op_byte = instr_op_q[7:0];

  always_comb begin
    taken = (op_byte == JMP_OP);
`ifdef FETCH_BRANCH_EN
    if ((op_byte == BRZ_OP) && zero_flag) begin
      taken = 1'b1;
    end
`endif
  end

`ifndef FETCH_BRANCH_EN
  logic unused_branch;
  assign unused_branch = ^{zero_flag, BRZ_OP};
`endif

  always_comb begin
    state_d     = state_q;
    instr_op_d  = instr_op_q;
    instr_arg_d = instr_arg_q;
    mem_req     = 1'b0;
    pc_inc_en   = 1'b0;
    instr_valid = 1'b0;
    pc_in       = pc_value;

    unique case (state_q)
      StIdle: begin
        state_d = StFetchOp;
      end
      StFetchOp: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_inc_en  = 1'b1;
          instr_op_d = mem_rdata;
          if (is_two_byte(mem_rdata[7:0])) begin
            state_d = StFetchArg;
          end else begin
            instr_arg_d = '0;
            state_d     = StIssue;
          end
        end
      end
      StFetchArg: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_inc_en   = 1'b1;
          instr_arg_d = mem_rdata;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_d = taken ? StJump : StFetchOp;
        end
      end
      StJump: begin
        // Load cycle: increment stays low so the counter takes pc_in.
        pc_in   = ADDR_W'(instr_arg_q);
        state_d = StFetchOp;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      instr_op_q  <= '0;
      instr_arg_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_op_q  <= instr_op_d;
      instr_arg_q <= instr_arg_d;
    end
  end

  assign mem_addr  = pc_value;
  assign instr_op  = instr_op_q;
  assign instr_arg = instr_arg_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: external PC and memory, instruction-level reference model.
module tb_fetch_sequencer;

`ifdef FETCH_BRANCH_EN
  localparam bit BrEn = 1'b1;
`else
  localparam bit BrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] pc;
  logic [7:0] pc_in;
  logic       pc_inc_en;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_op;
  logic [7:0] instr_arg;
  logic       zero_flag;

  logic [7:0] mem [256];
  logic [7:0] model_pc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_value   (pc),
    .pc_in      (pc_in),
    .pc_inc_en  (pc_inc_en),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op   (instr_op),
    .instr_arg  (instr_arg),
    .zero_flag  (zero_flag)
  );

  // Program counter living beside the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= 8'h00;
    else if (pc_inc_en) pc <= pc + 8'd1;
    else pc <= pc_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Serve one memory read with wait_n idle cycles before the ack.
  task automatic serve_fetch(input int unsigned wait_n, output logic [7:0] addr);
    int n;
    n = 0;
    mem_ack = 1'b0;
    #1;
    while (!mem_req && n < 4) begin
      cyc();
      #1;
      n++;
    end
    chk("req_seen", mem_req, 1);
    addr = mem_addr;
    for (int i = 0; i < int'(wait_n); i++) begin
      chk("wait_noinc", pc_inc_en, 0);
      chk("wait_pcin", pc_in, pc);
      cyc();
      #1;
      chk("wait_req", mem_req, 1);
      chk("wait_addr", mem_addr, addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = mem[addr];
    #1;
    chk("inc_pulse", pc_inc_en, 1);
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);
  endtask

  // Hold instr_ready low for stall cycles, then accept with the given zero flag.
  task automatic serve_issue(input int unsigned stall, input logic z,
                             output logic [7:0] op_s, output logic [7:0] arg_s);
    int n;
    n = 0;
    #1;
    while (!instr_valid && n < 4) begin
      cyc();
      #1;
      n++;
    end
    chk("valid_seen", instr_valid, 1);
    op_s  = instr_op;
    arg_s = instr_arg;
    for (int i = 0; i < int'(stall); i++) begin
      instr_ready = 1'b0;
      mem_ack     = 1'($urandom_range(0, 1));
      mem_rdata   = 8'($urandom);
      zero_flag   = 1'($urandom_range(0, 1));
      #1;
      chk("stall_valid", instr_valid, 1);
      chk("stall_op", instr_op, op_s);
      chk("stall_arg", instr_arg, arg_s);
      chk("stall_noreq", mem_req, 0);
      chk("stall_noinc", pc_inc_en, 0);
      chk("stall_pcin", pc_in, pc);
      cyc();
      #1;
    end
    mem_ack     = 1'b0;
    instr_ready = 1'b1;
    zero_flag   = z;
    #1;
    chk("hs_valid", instr_valid, 1);
    chk("hs_op", instr_op, op_s);
    cyc();
    instr_ready = 1'b0;
  endtask

  // One instruction: expectation comes from opcode rules applied to memory contents.
  task automatic run_instr(input int unsigned w_op, input int unsigned w_arg,
                           input int unsigned stall, input logic z);
    logic [7:0] e_op, e_arg, e_next, nxt, a, op_s, arg_s;
    logic       two, taken;
    nxt    = model_pc + 8'd1;
    e_op   = mem[model_pc];
    two    = (e_op >= 8'hC0);
    e_arg  = two ? mem[nxt] : 8'h00;
    taken  = (e_op == 8'hC0) || (BrEn && (e_op == 8'hC1) && z);
    e_next = taken ? e_arg : (two ? model_pc + 8'd2 : nxt);
    serve_fetch(w_op, a);
    chk("op_addr", a, model_pc);
    if (two) begin
      serve_fetch(w_arg, a);
      chk("arg_addr", a, nxt);
    end
    serve_issue(stall, z, op_s, arg_s);
    chk("issue_op", op_s, e_op);
    chk("issue_arg", arg_s, e_arg);
    if (taken) begin
      #1;
      chk("jmp_pcin", pc_in, e_arg);
      chk("jmp_noinc", pc_inc_en, 0);
      chk("jmp_noreq", mem_req, 0);
      cyc();
    end
    model_pc = e_next;
  endtask

  task automatic fill_random();
    int unsigned r;
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) mem[i] = 8'hC0;
      else if (r < 4) mem[i] = 8'hC1;
      else if (r < 6) mem[i] = {2'b11, 6'($urandom)};
      else mem[i] = 8'($urandom_range(0, 8'hBF));
    end
  endtask

  initial begin
    logic [7:0] a;
    int k;
    mem_ack     = 1'b0;
    mem_rdata   = 8'h00;
    instr_ready = 1'b0;
    zero_flag   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hC0; mem[8'h01] = 8'h10;
    mem[8'h10] = 8'h05;
    mem[8'h11] = 8'hC0; mem[8'h12] = 8'h20;
    mem[8'h20] = 8'hC1; mem[8'h21] = 8'h50;
    mem[8'h22] = 8'hC0; mem[8'h23] = 8'h30;
    mem[8'h50] = 8'hC0; mem[8'h51] = 8'h20;
    mem[8'h30] = 8'hC0; mem[8'h31] = 8'h40;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'hFF;
    mem[8'hFF] = 8'hD3;
    mem[8'h02] = 8'hC3; mem[8'h03] = 8'h77;

    #1 rst_n = 1'b0;
    mem_ack = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_inc", pc_inc_en, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_op", instr_op, 0);
    chk("rst_arg", instr_arg, 0);
    chk("rst_pcin", pc_in, 8'h00);
    mem_ack = 1'b0;
    rst_n   = 1'b1;
    cyc();
    #1;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 8'h00);
    model_pc = 8'h00;

    run_instr(0, 1, 0, 1'b0);
    run_instr(2, 0, 5, 1'b0);
    run_instr(1, 1, 0, 1'b0);
    k = 0;
    while (model_pc != 8'h30 && k < 6) begin
      run_instr(0, 1, 1, (k == 0));
      k++;
    end
    run_instr(0, 0, 1, 1'b0);
    run_instr(1, 0, 0, 1'b0);
    run_instr(0, 2, 2, 1'b0);
    run_instr(0, 0, 0, 1'b0);

    // Reset while waiting on the argument byte.
    serve_fetch(1, a);
    chk("mid_op_addr", a, model_pc);
    #1;
    chk("argfetch_req", mem_req, 1);
    chk("argfetch_addr", mem_addr, 8'h03);
    mem_ack = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_inc", pc_inc_en, 0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_op", instr_op, 0);
    chk("mid_rst_arg", instr_arg, 0);
    chk("mid_rst_pcin", pc_in, pc);
    mem_ack = 1'b0;
    fill_random();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    #1;
    chk("resume_req", mem_req, 1);
    chk("resume_addr", mem_addr, 8'h00);
    model_pc = 8'h00;

    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program address width.
REQ-002 SHALL have parameter DATA_W, default 8, instruction byte width.
REQ-003 SHALL have parameter JMP_OP, default 8'hC0, unconditional-jump opcode.
REQ-004 SHALL have parameter BRZ_OP, default 8'hC1, branch-if-zero opcode.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port pc_value  in  ADDR_W  current program-counter output.
REQ-008 SHALL have port pc_in  out  ADDR_W  value the program counter loads when pc_inc_en is low.
REQ-009 SHALL have port pc_inc_en  out  1  program-counter increment strobe.
REQ-010 SHALL have ports mem_req out 1, mem_addr out ADDR_W, mem_ack in 1, mem_rdata in DATA_W: instruction-memory read handshake.
REQ-011 SHALL have ports instr_valid out 1, instr_ready in 1, instr_op out DATA_W, instr_arg out DATA_W: decode-side handshake.
REQ-012 SHALL have port zero_flag  in  1  ALU zero flag for conditional branches.

Function
REQ-013 SHALL implement states IDLE, FETCH_OP, FETCH_ARG, ISSUE, JUMP.
REQ-014 SHALL move IDLE -> FETCH_OP unconditionally on the first clock after reset release.
REQ-015 SHALL assert mem_req with mem_addr = pc_value in FETCH_OP/FETCH_ARG, held until the cycle mem_ack is sampled high.
REQ-016 SHALL ignore mem_ack when mem_req is low.
REQ-017 SHALL, on opcode ack, latch mem_rdata into instr_op and pulse pc_inc_en for exactly that cycle.
REQ-018 SHALL treat opcode[7:6] == 2'b11 as two-byte: go to FETCH_ARG; otherwise set instr_arg = 0 and go to ISSUE.
REQ-019 SHALL, on argument ack, latch mem_rdata into instr_arg, pulse pc_inc_en, go to ISSUE.
REQ-020 SHALL drive pc_in = pc_value in every cycle that is neither an increment nor a jump load, so the counter holds.
REQ-021 SHALL hold instr_valid high in ISSUE with stable instr_op/instr_arg until instr_ready is sampled high.
REQ-022 SHALL, on accepted handshake, go to JUMP if the instruction is taken, else to FETCH_OP.
REQ-023 SHALL, in JUMP, drive pc_in = instr_arg with pc_inc_en low for one cycle, then go to FETCH_OP.
REQ-024 SHALL treat JMP_OP as always taken.
REQ-025 SHALL evaluate BRZ_OP taken iff zero_flag is high in the handshake cycle.
REQ-026 SHALL let address arithmetic wrap modulo 2^ADDR_W: an argument fetch after opcode at 0xFF reads 0x00.
REQ-027 SHALL keep the one-cycle PC update latency: mem_addr in FETCH_ARG/FETCH_OP is the post-increment or post-load pc_value.
REQ-028 SHALL assert at most one of pc_inc_en or a jump load per cycle.

Reset
REQ-029 SHALL on rst_n low, asynchronously, force state IDLE; mem_req, pc_inc_en, instr_valid = 0; instr_op, instr_arg = 0; pc_in = pc_value.
REQ-030 SHALL abandon any in-flight fetch or issue when reset asserts mid-operation, and restart from IDLE.

Configuration
REQ-031 SHALL, with FETCH_BRANCH_EN defined, support BRZ_OP per REQ-025.
REQ-032 SHALL, without FETCH_BRANCH_EN, treat BRZ_OP as an ordinary two-byte non-jump instruction and ignore zero_flag.

Structure
REQ-033 SHALL place ADDR_W/DATA_W defaults, JMP_OP, BRZ_OP and the state enumeration in shared package cpu_pkg.
REQ-034 SHALL be a single module with no sub-modules; the program counter is instantiated alongside it, not inside.

Verification
REQ-035 SHALL cover one-byte fetch: pc 0x10, rdata 0x05 after 2-cycle ack wait -> one pc_inc_en pulse, instr_op 0x05, arg 0x00, valid until ready.
REQ-036 SHALL cover jump: opcode 0xC0 at 0x20, arg 0x40 -> two inc pulses, issue, one-cycle pc_in 0x40 load, next mem_addr 0x40.
REQ-037 SHALL cover BRZ with FETCH_BRANCH_EN: zero_flag 1 -> next fetch at arg; zero_flag 0 -> next fetch at 0x22 (opcode at 0x20).
REQ-038 SHALL cover wrap: two-byte opcode at 0xFF -> argument fetched at mem_addr 0x00.
REQ-039 SHALL cover backpressure: instr_ready low 5 cycles -> instr_valid, op, arg stable; no mem_req; pc_in = pc_value.
REQ-040 SHALL cover reset mid-FETCH_ARG: rst_n low -> mem_req 0 immediately; after release, fetch resumes at the reset PC (0x00).
